// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the SRAM-backed FWFT FIFO controller.
package sram_fifo_ctrl_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned OBUF_DEPTH  = 2;
  localparam int unsigned SRAM_RD_LAT = 1;
  localparam int unsigned OBUF_CW     = clog2(OBUF_DEPTH + 1);

endpackage

// File: rtl/gen_sram.sv
// SRAM macro model: one write port with byte strobes, one registered read port.
module gen_sram #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
) (
  input  logic                    clk_i,
  input  logic                    en_w_i,
  input  logic [AW-1:0]           addr_w_i,
  input  logic [DW-1:0]           data_w_i,
  input  logic [(DW+7)/8-1:0]     wstrb_i,
  input  logic                    en_r_i,
  input  logic [AW-1:0]           addr_r_i,
  output logic [DW-1:0]           data_r_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] wmask;

  for (genvar g = 0; g < DW; g++) begin : g_mask
    assign wmask[g] = wstrb_i[g/8];
  end

  // Storage is deliberately unreset; the controller never reads an unwritten word.
  always_ff @(posedge clk_i) begin
    if (en_w_i) mem_q[addr_w_i] <= (mem_q[addr_w_i] & ~wmask) | (data_w_i & wmask);
    if (en_r_i) data_r_o <= mem_q[addr_r_i];
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FWFT FIFO controller: SRAM pointer/count management with read-ahead into a
// 2-entry output buffer that hides the SRAM read latency.
module sram_fifo_ctrl
  import sram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [DW-1:0] enq_data,
  output logic          deq_valid,
  input  logic          deq_ready,
  output logic [DW-1:0] deq_data,
  output logic [AW+1:0] count,
  input  logic          flush
);

  localparam int unsigned DP = 2**AW;
  localparam int unsigned CW = AW + 2;
  localparam int unsigned MW = AW + 1;
  localparam int unsigned OW = OBUF_CW + 1;

  logic [AW-1:0]          wptr_q, wptr_d;
  logic [AW-1:0]          rptr_q, rptr_d;
  logic [MW-1:0]          mem_cnt_q, mem_cnt_d;
  logic [SRAM_RD_LAT-1:0] inflight_q, inflight_d;
  logic [OBUF_CW-1:0]     obuf_cnt_q, obuf_cnt_d, obuf_cnt_tmp;
  logic [DW-1:0]          obuf_q [OBUF_DEPTH];
  logic [DW-1:0]          obuf_d [OBUF_DEPTH];

  logic          enq_fire, deq_fire, rd_issue, rd_data_vld;
  logic [OW-1:0] occ_after_deq;
  logic [DW-1:0] sram_rdata;

  assign enq_ready   = (mem_cnt_q < MW'(DP));
  assign deq_valid   = (obuf_cnt_q != '0);
  assign deq_data    = obuf_q[0];
  assign enq_fire    = enq_valid & enq_ready & ~flush;
  assign deq_fire    = deq_valid & deq_ready & ~flush;
  assign rd_data_vld = inflight_q[SRAM_RD_LAT-1];
  assign count       = CW'(mem_cnt_q) + CW'($countones(inflight_q)) + CW'(obuf_cnt_q);

  // Read ahead only while the buffer, counting words already in flight, has room.
  assign occ_after_deq = OW'(obuf_cnt_q) + OW'($countones(inflight_q)) - OW'(deq_fire);
  assign rd_issue      = ~flush & (mem_cnt_q != '0) & (occ_after_deq < OW'(OBUF_DEPTH));

  gen_sram #(
    .DW(DW),
    .AW(AW)
  ) u_sram (
    .clk_i   (CLK),
    .en_w_i  (enq_fire),
    .addr_w_i(wptr_q),
    .data_w_i(enq_data),
    .wstrb_i ('1),
    .en_r_i  (rd_issue),
    .addr_r_i(rptr_q),
    .data_r_o(sram_rdata)
  );

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    mem_cnt_d    = mem_cnt_q;
    inflight_d   = inflight_q;
    obuf_cnt_d   = obuf_cnt_q;
    obuf_cnt_tmp = obuf_cnt_q;
    obuf_d       = obuf_q;
    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      mem_cnt_d  = '0;
      inflight_d = '0;
      obuf_cnt_d = '0;
    end else begin
      if (enq_fire) wptr_d = wptr_q + AW'(1);
      if (rd_issue) rptr_d = rptr_q + AW'(1);
      mem_cnt_d  = mem_cnt_q + MW'(enq_fire) - MW'(rd_issue);
      inflight_d = (inflight_q << 1) | SRAM_RD_LAT'(rd_issue);
      // Pop first, then the arriving word lands in the first slot left free.
      if (deq_fire) begin
        obuf_d[0]    = obuf_q[1];
        obuf_cnt_tmp = obuf_cnt_q - OBUF_CW'(1);
      end
      if (rd_data_vld) begin
        if (obuf_cnt_tmp == '0) obuf_d[0] = sram_rdata;
        else                    obuf_d[1] = sram_rdata;
        obuf_cnt_d = obuf_cnt_tmp + OBUF_CW'(1);
      end else begin
        obuf_cnt_d = obuf_cnt_tmp;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= '0;
      obuf_cnt_q <= '0;
      obuf_q[0]  <= '0;
      obuf_q[1]  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
      obuf_cnt_q <= obuf_cnt_d;
      obuf_q     <= obuf_d;
    end
  end

  a_obuf_max: assert property (@(posedge CLK) disable iff (!RSTn)
    obuf_cnt_q <= OBUF_CW'(OBUF_DEPTH));
  a_obuf_no_overrun: assert property (@(posedge CLK) disable iff (!RSTn)
    !(rd_data_vld && !flush && !deq_fire && obuf_cnt_q == OBUF_CW'(OBUF_DEPTH)));
  a_mem_cnt_max: assert property (@(posedge CLK) disable iff (!RSTn)
    mem_cnt_q <= MW'(DP));

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_sram_fifo_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 2;
  localparam int unsigned DP = 4;
  localparam int unsigned CW = 4;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          enq_valid = 1'b0;
  logic          enq_ready;
  logic [DW-1:0] enq_data = '0;
  logic          deq_valid;
  logic          deq_ready = 1'b0;
  logic [DW-1:0] deq_data;
  logic [CW-1:0] count;
  logic          flush = 1'b0;

  always #5 CLK = ~CLK;

  sram_fifo_ctrl #(
    .DW(DW),
    .AW(AW)
  ) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .enq_valid(enq_valid),
    .enq_ready(enq_ready),
    .enq_data (enq_data),
    .deq_valid(deq_valid),
    .deq_ready(deq_ready),
    .deq_data (deq_data),
    .count    (count),
    .flush    (flush)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  // Reference model: entries in FIFO order; vis<0 means still in SRAM, otherwise
  // the cycle at which the entry becomes visible at the head (read issue + 2).
  logic [DW-1:0] mq_data[$];
  int            mq_vis[$];

  logic          s_rdy, s_val;
  logic [CW-1:0] s_cnt;
  logic [DW-1:0] s_dat;

  typedef struct {
    logic          ev;
    logic [DW-1:0] ed;
    logic          dr;
    logic          e_rdy;
    logic          e_val;
    logic [CW-1:0] e_cnt;
    logic [DW-1:0] e_dat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic model_clear();
    mq_data.delete();
    mq_vis.delete();
  endtask

  task automatic cycle(input logic ev, input logic [DW-1:0] ed, input logic dr,
                       input logic fl, output logic fired, output logic [DW-1:0] fdata);
    int   mem_items;
    int   out_occ;
    logic e_rdy, e_val;
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    flush     = fl;
    @(negedge CLK);
    s_rdy = enq_ready; s_val = deq_valid; s_cnt = count; s_dat = deq_data;
    mem_items = 0;
    foreach (mq_vis[i]) if (mq_vis[i] < 0) mem_items++;
    out_occ = mq_vis.size() - mem_items;
    e_rdy = (mem_items < DP);
    e_val = (mq_vis.size() > 0) && (mq_vis[0] >= 0) && (mq_vis[0] <= cyc);
    chk("enq_ready", 64'(enq_ready), 64'(e_rdy));
    chk("deq_valid", 64'(deq_valid), 64'(e_val));
    chk("count", 64'(count), 64'(mq_vis.size()));
    if (e_val) chk("deq_data", 64'(deq_data), 64'(mq_data[0]));
    fired = e_val & dr & ~fl;
    fdata = deq_data;
    if (fl) begin
      model_clear();
    end else begin
      if (fired) begin
        void'(mq_data.pop_front());
        void'(mq_vis.pop_front());
      end
      if (mem_items > 0 && (out_occ - int'(fired)) < 2) begin
        for (int i = 0; i < mq_vis.size(); i++) begin
          if (mq_vis[i] < 0) begin
            mq_vis[i] = cyc + 2;
            break;
          end
        end
      end
      if (ev && e_rdy) begin
        mq_data.push_back(ed);
        mq_vis.push_back(-1);
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t          vt[10];
    logic          f;
    logic [DW-1:0] fd;
    logic [DW-1:0] got[$];
    int            first_fire, last_fire, nfire;

    for (int i = 0; i < 10; i++) begin
      vt[i].ev = 1'b0; vt[i].ed = '0; vt[i].dr = 1'b1;
      vt[i].e_rdy = 1'b1; vt[i].e_val = 1'b0; vt[i].e_cnt = '0; vt[i].e_dat = '0;
    end
    vt[5].ev = 1'b1; vt[5].ed = 32'hDEADBEEF;
    vt[6].e_cnt = 4'd1;
    vt[7].e_cnt = 4'd1;
    vt[8].e_cnt = 4'd1; vt[8].e_val = 1'b1; vt[8].e_dat = 32'hDEADBEEF;

    // Reset state
    #2;
    chk("reset_enq_ready", 64'(enq_ready), 64'd1);
    chk("reset_deq_valid", 64'(deq_valid), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b1;
    model_clear();
    cyc = 0;

    // Single word, table driven
    for (int i = 0; i < 10; i++) begin
      cycle(vt[i].ev, vt[i].ed, vt[i].dr, 1'b0, f, fd);
      chk("t1_enq_ready", 64'(s_rdy), 64'(vt[i].e_rdy));
      chk("t1_deq_valid", 64'(s_val), 64'(vt[i].e_val));
      chk("t1_count", 64'(s_cnt), 64'(vt[i].e_cnt));
      if (vt[i].e_val) chk("t1_deq_data", 64'(s_dat), 64'(vt[i].e_dat));
    end

    // Fill to capacity with consumer stalled, then drain
    for (int k = 0; k < 10; k++) cycle(1'b1, DW'(k), 1'b0, 1'b0, f, fd);
    cycle(1'b0, '0, 1'b0, 1'b0, f, fd);
    chk("full_count", 64'(s_cnt), 64'd6);
    chk("full_enq_ready", 64'(s_rdy), 64'd0);
    got.delete();
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, f, fd);
      if (f) got.push_back(fd);
    end
    chk("drain_n", 64'(got.size()), 64'd6);
    foreach (got[i]) chk("drain_order", 64'(got[i]), 64'(i));
    chk("drain_enq_ready", 64'(s_rdy), 64'd1);

    // Streaming across pointer wrap
    got.delete();
    nfire = 0; first_fire = -1; last_fire = -1;
    for (int k = 0; k < 134; k++) begin
      cycle(k < 128, DW'(32'h100 + k), 1'b1, 1'b0, f, fd);
      if (f) begin
        got.push_back(fd);
        nfire++;
        if (first_fire < 0) first_fire = k;
        last_fire = k;
      end
    end
    chk("stream_n", 64'(nfire), 64'd128);
    chk("stream_first_latency", 64'(first_fire), 64'd3);
    chk("stream_no_bubble", 64'(last_fire - first_fire), 64'd127);
    foreach (got[i]) if (got[i] !== DW'(32'h100 + i)) chk("stream_order", 64'(got[i]), 64'(32'h100 + i));

    // Random traffic
    for (int k = 0; k < 2000; k++)
      cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0, f, fd);
    for (int k = 0; k < 10; k++) cycle(1'b0, '0, 1'b1, 1'b0, f, fd);

    // Flush with 5 entries held; the flush-cycle enq and deq are dropped
    for (int k = 0; k < 5; k++) cycle(1'b1, DW'(32'h50 + k), 1'b0, 1'b0, f, fd);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, f, fd);
    chk("pre_flush_count", 64'(s_cnt), 64'd5);
    cycle(1'b1, DW'(32'h77), 1'b1, 1'b1, f, fd);
    cycle(1'b0, '0, 1'b0, 1'b0, f, fd);
    chk("flush_count", 64'(s_cnt), 64'd0);
    chk("flush_deq_valid", 64'(s_val), 64'd0);
    got.delete();
    cycle(1'b1, DW'(32'hA5), 1'b1, 1'b0, f, fd);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, f, fd);
      if (f) got.push_back(fd);
    end
    chk("flush_after_n", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("flush_after_data", 64'(got[0]), 64'hA5);

    // Asynchronous reset pulse between edges with 5 entries held
    for (int k = 0; k < 5; k++) cycle(1'b1, DW'(32'h60 + k), 1'b0, 1'b0, f, fd);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, f, fd);
    RSTn = 1'b0;
    #2;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_deq_valid", 64'(deq_valid), 64'd0);
    chk("arst_enq_ready", 64'(enq_ready), 64'd1);
    #1;
    RSTn = 1'b1;
    model_clear();
    cycle(1'b0, '0, 1'b0, 1'b0, f, fd);
    chk("arst_next_count", 64'(s_cnt), 64'd0);
    got.delete();
    cycle(1'b1, DW'(32'hA5), 1'b1, 1'b0, f, fd);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, f, fd);
      if (f) got.push_back(fd);
    end
    chk("arst_after_n", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("arst_after_data", 64'(got[0]), 64'hA5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
